// File: rtl/isa_dispatch_pkg.sv
// Shared constants for the instruction fetch/dispatch sequencer: opcodes, instruction
// field positions and the dispatch state encoding.
package isa_pkg;

  localparam int unsigned InstrW    = 32;
  localparam int unsigned OpcodeW   = 8;
  localparam int unsigned RegW      = 4;
  localparam int unsigned OpcodeLsb = 24;
  localparam int unsigned R0Lsb     = 20;
  localparam int unsigned R1Lsb     = 16;
  localparam int unsigned R2Lsb     = 12;

  localparam logic [OpcodeW-1:0] OP_NOP      = 8'h00;
  localparam logic [OpcodeW-1:0] OP_HALT     = 8'hFF;
  localparam logic [OpcodeW-1:0] OP_ALU_BASE = 8'h01;

  typedef enum logic [2:0] {
    StFetch,
    StWaitMem,
    StDecode,
    StExec,
    StRelease,
    StHalted,
    StTrap
  } state_e;

endpackage

// File: rtl/isa_dispatch_if.sv
// Instruction-memory read port and per-unit execute handshake of the dispatch sequencer.
interface isa_dispatch_if #(
  parameter int unsigned PC_WIDTH  = 16,
  parameter int unsigned NUM_UNITS = 4
);
  logic [PC_WIDTH-1:0]  mem_addr;
  logic                 mem_re;
  logic [31:0]          mem_rdata;
  logic                 mem_ready;
  logic [NUM_UNITS-1:0] unit_en;
  logic [NUM_UNITS-1:0] unit_finished;

  modport master (
    output mem_addr, mem_re, unit_en,
    input  mem_rdata, mem_ready, unit_finished
  );

  modport slave (
    input  mem_addr, mem_re, unit_en,
    output mem_rdata, mem_ready, unit_finished
  );
endinterface

// File: rtl/isa_dispatch_decode.sv
// Combinational opcode classifier: one-hot execute-unit select plus NOP/HALT/illegal flags.
module isa_decode
  import isa_pkg::*;
#(
  parameter int unsigned NUM_UNITS = 4
) (
  input  logic [OpcodeW-1:0]   opcode_i,
  output logic [NUM_UNITS-1:0] unit_sel_o,
  output logic                 is_nop_o,
  output logic                 is_halt_o,
  output logic                 is_illegal_o
);

  always_comb begin
    unit_sel_o = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      if (opcode_i == OpcodeW'(OP_ALU_BASE + i)) unit_sel_o[i] = 1'b1;
    end
    is_nop_o     = (opcode_i == OP_NOP);
    is_halt_o    = (opcode_i == OP_HALT);
    is_illegal_o = !(is_nop_o || is_halt_o || (|unit_sel_o));
  end

endmodule

// File: rtl/isa_dispatch.sv
// Fetch/dispatch sequencer: fetch, decode, enable one execute unit until it finishes, retire.
// Optional EXEC watchdog enabled by defining ISA_DISPATCH_TIMEOUT_EN.
module isa_dispatch
  import isa_pkg::*;
#(
  parameter int unsigned PC_WIDTH       = 16,
  parameter int unsigned NUM_UNITS      = 4,
  parameter int unsigned RESET_PC       = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  isa_dispatch_if.master      bus,
  output logic [RegW-1:0]     r0,
  output logic [RegW-1:0]     r1,
  output logic [RegW-1:0]     r2,
  output logic [PC_WIDTH-1:0] pc,
  output logic                retire,
  output logic                halted,
  output logic                trap
);

  state_e               state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [InstrW-1:0]    ir_q, ir_d;
  logic [NUM_UNITS-1:0] unit_en_q, unit_en_d;
  logic                 mem_re_q, mem_re_d;
  logic                 retire_q, retire_d;
  logic                 halted_q, halted_d;
  logic                 trap_q, trap_d;

  logic [NUM_UNITS-1:0] unit_sel;
  logic                 is_nop, is_halt, is_illegal;
  logic                 unit_done;
  logic                 unused_ir;

  isa_decode #(
    .NUM_UNITS(NUM_UNITS)
  ) u_decode (
    .opcode_i    (ir_q[OpcodeLsb +: OpcodeW]),
    .unit_sel_o  (unit_sel),
    .is_nop_o    (is_nop),
    .is_halt_o   (is_halt),
    .is_illegal_o(is_illegal)
  );

  // Only the enabled unit's finished bit counts; the others are ignored.
  assign unit_done = |(unit_en_q & bus.unit_finished);
  assign unused_ir = ^ir_q[R2Lsb-1:0];

`ifdef ISA_DISPATCH_TIMEOUT_EN
  localparam int unsigned CntW =
      ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tmo_hit;
  assign tmo_hit = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    unit_en_d = unit_en_q;
    mem_re_d  = mem_re_q;
    retire_d  = 1'b0;
    halted_d  = halted_q;
    trap_d    = trap_q;
`ifdef ISA_DISPATCH_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      StFetch: begin
        mem_re_d = 1'b1;
        state_d  = StWaitMem;
      end
      StWaitMem: begin
        if (bus.mem_ready) begin
          ir_d     = bus.mem_rdata;
          mem_re_d = 1'b0;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        if (is_illegal) begin
          trap_d  = 1'b1;
          state_d = StTrap;
        end else if (is_halt) begin
          halted_d = 1'b1;
          state_d  = StHalted;
        end else if (is_nop) begin
          retire_d = 1'b1;
          state_d  = StRelease;
        end else begin
          unit_en_d = unit_sel;
          state_d   = StExec;
`ifdef ISA_DISPATCH_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      StExec: begin
        if (unit_done) begin
          unit_en_d = '0;
          retire_d  = 1'b1;
          state_d   = StRelease;
`ifdef ISA_DISPATCH_TIMEOUT_EN
        end else if (tmo_hit) begin
          unit_en_d = '0;
          trap_d    = 1'b1;
          state_d   = StTrap;
        end else begin
          cnt_d = cnt_q + CntW'(1);
`endif
        end
      end
      StRelease: begin
        pc_d    = pc_q + PC_WIDTH'(1);
        state_d = StFetch;
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      pc_q      <= PC_WIDTH'(RESET_PC);
      ir_q      <= '0;
      unit_en_q <= '0;
      mem_re_q  <= 1'b0;
      retire_q  <= 1'b0;
      halted_q  <= 1'b0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      unit_en_q <= unit_en_d;
      mem_re_q  <= mem_re_d;
      retire_q  <= retire_d;
      halted_q  <= halted_d;
      trap_q    <= trap_d;
    end
  end

`ifdef ISA_DISPATCH_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

  assign bus.mem_addr = pc_q;
  assign bus.mem_re   = mem_re_q;
  assign bus.unit_en  = unit_en_q;
  assign pc           = pc_q;
  assign r0           = ir_q[R0Lsb +: RegW];
  assign r1           = ir_q[R1Lsb +: RegW];
  assign r2           = ir_q[R2Lsb +: RegW];
  assign retire       = retire_q;
  assign halted       = halted_q;
  assign trap         = trap_q;

endmodule
